// File: rtl/mul_seq_pkg.sv
// Shared types and sizes for the sequential 32x32 multiplier controller.
package mul_seq_pkg;

  localparam int unsigned PP_STEPS = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned OP_W     = 32;
  localparam int unsigned PROD_W   = 64;
  localparam int unsigned STEP_W   = $clog2(PP_STEPS);

  typedef logic req_id_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  // Two's-complement magnitude; 0x8000_0000 maps to itself and reads as unsigned.
  function automatic logic [OP_W-1:0] op_mag(input logic [OP_W-1:0] x);
    return x[OP_W-1] ? OP_W'(~x + OP_W'(1)) : x;
  endfunction

  function automatic logic [BYTE_W-1:0] byte_sel(input logic [OP_W-1:0] x,
                                                 input logic [1:0]      idx);
    return x[32'(idx) * BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the winner loses priority once accepted.
module rr_arb2
  import mul_seq_pkg::*;
#(
  parameter bit ARB_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt_c,
  output req_id_t    gnt_id_c
);

  req_id_t prio;

  // Lone requester wins outright; a tie goes to the holder of priority.
  always_comb begin
    gnt_id_c = prio;
    if (req[0] && !req[1]) gnt_id_c = 1'b0;
    else if (req[1] && !req[0]) gnt_id_c = 1'b1;
    gnt_c = '0;
    if (en && req[gnt_id_c]) gnt_c[gnt_id_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= ARB_INIT;
    end else if (|gnt_c) begin
      prio <= ~gnt_id_c;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 multiplier controller driving an external 8x8 multiplier and
// 16-step accumulator. Define SIGNED_MUL_EN to honour the per-request signed flag.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter bit ARB_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_signed,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_product,
  output logic [7:0]  mul_a_byte,
  output logic [7:0]  mul_b_byte,
  output logic        acc_start,
  input  logic [63:0] acc_product,
  output logic        busy
);

  state_e            state;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_nx_c;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  req_id_t           id_q;
  logic [1:0]        gnt_c;
  req_id_t           gnt_id_c;
  logic              accept_c;
  logic [OP_W-1:0]   sel_a_c;
  logic [OP_W-1:0]   sel_b_c;

  rr_arb2 #(.ARB_INIT(ARB_INIT)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      ({req1_valid, req0_valid}),
    .en       (state == ST_IDLE),
    .gnt_c    (gnt_c),
    .gnt_id_c (gnt_id_c)
  );

  assign req0_ready = gnt_c[0];
  assign req1_ready = gnt_c[1];
  assign accept_c   = |gnt_c;
  assign sel_a_c    = gnt_id_c ? req1_a : req0_a;
  assign sel_b_c    = gnt_id_c ? req1_b : req0_b;
  assign step_nx_c  = step + STEP_W'(1);

`ifdef SIGNED_MUL_EN
  logic neg_q;
  logic sel_s_c;
  assign sel_s_c = gnt_id_c ? req1_signed : req0_signed;
`else
  logic unused_signed;
  assign unused_signed = req0_signed ^ req1_signed;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      step        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
`ifdef SIGNED_MUL_EN
      neg_q       <= 1'b0;
`endif
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_product <= '0;
      mul_a_byte  <= '0;
      mul_b_byte  <= '0;
      acc_start   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
`ifdef SIGNED_MUL_EN
            a_q   <= sel_s_c ? op_mag(sel_a_c) : sel_a_c;
            b_q   <= sel_s_c ? op_mag(sel_b_c) : sel_b_c;
            neg_q <= sel_s_c & (sel_a_c[OP_W-1] ^ sel_b_c[OP_W-1]);
`else
            a_q   <= sel_a_c;
            b_q   <= sel_b_c;
`endif
            id_q      <= gnt_id_c;
            acc_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          step       <= '0;
          mul_a_byte <= byte_sel(a_q, 2'b00);
          mul_b_byte <= byte_sel(b_q, 2'b00);
          state      <= ST_RUN;
        end
        // Byte registers are loaded one step ahead so they line up with step.
        ST_RUN: begin
          if (step == STEP_W'(PP_STEPS - 1)) begin
            mul_a_byte <= '0;
            mul_b_byte <= '0;
            acc_start  <= 1'b0;
            state      <= ST_CAPTURE;
          end else begin
            step       <= step_nx_c;
            mul_a_byte <= byte_sel(a_q, step_nx_c[1:0]);
            mul_b_byte <= byte_sel(b_q, step_nx_c[STEP_W-1:2]);
          end
        end
        ST_CAPTURE: begin
`ifdef SIGNED_MUL_EN
          rsp_product <= neg_q ? PROD_W'(~acc_product + PROD_W'(1)) : acc_product;
`else
          rsp_product <= acc_product;
`endif
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a behavioural partial-product accumulator.
module tb_mul_seq_ctrl;

`ifdef SIGNED_MUL_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_signed;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_signed;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_product;
  logic [7:0]  mul_a_byte, mul_b_byte;
  logic        acc_start;
  logic [63:0] acc_product;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int both_ready_seen = 0;
  int ready_busy_seen = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_signed (req0_signed),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_signed (req1_signed),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .mul_a_byte  (mul_a_byte),
    .mul_b_byte  (mul_b_byte),
    .acc_start   (acc_start),
    .acc_product (acc_product),
    .busy        (busy)
  );

  // External accumulator: first acc_start cycle clears, each following one adds a shifted byte product.
  logic        acc_run;
  logic [63:0] acc;
  int          acc_k;
  logic [15:0] byte_log[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_run <= 1'b0;
      acc     <= '0;
      acc_k   <= 0;
    end else if (!acc_start) begin
      acc_run <= 1'b0;
    end else if (!acc_run) begin
      acc_run <= 1'b1;
      acc     <= '0;
      acc_k   <= 0;
    end else begin
      acc   <= acc + ((64'(mul_a_byte) * 64'(mul_b_byte)) << (8 * ((acc_k % 4) + (acc_k / 4))));
      acc_k <= acc_k + 1;
      byte_log.push_back({mul_a_byte, mul_b_byte});
    end
  end
  assign acc_product = acc;

  always @(negedge clk) begin
    if (req0_ready && req1_ready) both_ready_seen++;
    if (busy && (req0_ready || req1_ready)) ready_busy_seen++;
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
    if (s && SIGNED_EN) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Drives one request and waits for its response; ok drops if a wait bound expires.
  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input bit s,
                        output logic [63:0] prod, output bit rid, output int cyc, output bit ok);
    int n;
    ok = 1'b1; prod = '0; rid = 1'b0; cyc = 0;
    @(negedge clk);
    if (id) begin req1_a = a; req1_b = b; req1_signed = s; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_signed = s; req0_valid = 1'b1; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready)) begin
      @(negedge clk); #1; n++;
      if (n > 200) begin ok = 1'b0; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid) begin
        @(posedge clk); #1; cyc++;
        if (cyc > 100) begin ok = 1'b0; break; end
      end
      prod = rsp_product; rid = rsp_id;
    end else begin
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_signed = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_signed = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rsp_valid, rsp_id, acc_start} !== 4'b0 || rsp_product !== 64'h0) begin
      errors++; $display("FAIL reset_outputs busy=%b rsp_valid=%b rsp_id=%b acc_start=%b product=%h want all 0", busy, rsp_valid, rsp_id, acc_start, rsp_product);
    end
    checks++;
    if ({mul_a_byte, mul_b_byte} !== 16'h0) begin
      errors++; $display("FAIL reset_bytes got %h/%h want 00/00", mul_a_byte, mul_b_byte);
    end
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; #1;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_gated got %b want 0", req0_ready);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] p; bit rid; int cyc; bit ok;
    run_op(1'b0, 32'h3, 32'h5, 1'b0, p, rid, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout no accept or response within bound"); end
    checks++;
    if (p !== 64'hF) begin errors++; $display("FAIL basic_product got %h want %h", p, 64'hF); end
    checks++;
    if (rid !== 1'b0) begin errors++; $display("FAIL basic_id got %b want 0", rid); end
    checks++;
    if (cyc !== 19) begin errors++; $display("FAIL basic_latency got %0d want 19", cyc); end
    finish_rsp();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle busy=%b rsp_valid=%b want 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_all_ones();
    logic [63:0] p; bit rid; int cyc; bit ok; int bad; logic [31:0] a, b; logic [15:0] want;
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, rid, cyc, ok);
    checks++;
    if (!ok || p !== 64'hFFFF_FFFE_0000_0001 || rid !== 1'b1) begin
      errors++; $display("FAIL all_ones got ok=%b id=%b product=%h want 1/1/%h", ok, rid, p, 64'hFFFF_FFFE_0000_0001);
    end
    finish_rsp();
    a = 32'h4433_2211; b = 32'h8877_6655;
    byte_log.delete();
    run_op(1'b1, a, b, 1'b0, p, rid, cyc, ok);
    checks++;
    if (byte_log.size() != 16) begin
      errors++; $display("FAIL byte_order_count got %0d want 16", byte_log.size());
    end else begin
      bad = -1;
      for (int k = 0; k < 16; k++) begin
        want = {8'((a >> (8 * (k % 4))) & 32'hFF), 8'((b >> (8 * (k / 4))) & 32'hFF)};
        if (byte_log[k] !== want && bad < 0) bad = k;
      end
      if (bad >= 0) begin
        errors++; $display("FAIL byte_order step %0d got %h want A%0d/B%0d", bad, byte_log[bad], bad % 4, bad / 4);
      end
    end
    checks++;
    if (!ok || p !== ref_mul(a, b, 1'b0)) begin
      errors++; $display("FAIL byte_order_product got %h want %h", p, ref_mul(a, b, 1'b0));
    end
    finish_rsp();
  endtask

  task automatic test_arbitration();
    logic [31:0] a0, b0, a1, b1; int n; bit gid; logic [63:0] exp;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    @(negedge clk);
    both_ready_seen = 0;
    reset_n = 1'b0;
    req0_a = a0; req0_b = b0; req0_signed = 1'b0; req0_valid = 1'b1;
    req1_a = a1; req1_b = b1; req1_signed = 1'b0; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 200) begin @(negedge clk); #1; n++; end
      gid = req1_ready;
      checks++;
      if (n >= 200 || gid !== 1'(i % 2)) begin
        errors++; $display("FAIL grant_order grant %0d got id %b want %0d", i, gid, i % 2);
      end
      @(posedge clk); #1;
      n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      exp = (i % 2) ? ref_mul(a1, b1, 1'b0) : ref_mul(a0, b0, 1'b0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_product !== exp) begin
        errors++; $display("FAIL grant_rsp %0d got valid=%b id=%b product=%h want 1/%0d/%h", i, rsp_valid, rsp_id, rsp_product, i % 2, exp);
      end
      finish_rsp();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (both_ready_seen != 0) begin
      errors++; $display("FAIL both_ready got %0d cycles want 0", both_ready_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] p, p1; bit rid, rid1; int cyc; bit ok, ok1; logic [31:0] a, b, a1, b1;
    a = $urandom; b = $urandom; a1 = $urandom; b1 = $urandom;
    run_op(1'b0, a, b, 1'b0, p, rid, cyc, ok);
    checks++;
    if (!ok || p !== ref_mul(a, b, 1'b0) || rid !== 1'b0) begin
      errors++; $display("FAIL hold_product got ok=%b id=%b product=%h want 1/0/%h", ok, rid, p, ref_mul(a, b, 1'b0));
    end
    req1_a = a1; req1_b = b1; req1_signed = 1'b0; req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_product !== p || rsp_id !== rid || busy !== 1'b1 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable cycle %0d got valid=%b id=%b busy=%b r1rdy=%b product=%h want 1/%b/1/0/%h",
                           c, rsp_valid, rsp_id, busy, req1_ready, rsp_product, rid, p);
      end
    end
    finish_rsp();
    run_op(1'b1, a1, b1, 1'b0, p1, rid1, cyc, ok1);
    checks++;
    if (!ok1 || p1 !== ref_mul(a1, b1, 1'b0) || rid1 !== 1'b1) begin
      errors++; $display("FAIL held_off_request got ok=%b id=%b product=%h want 1/1/%h", ok1, rid1, p1, ref_mul(a1, b1, 1'b0));
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    logic [63:0] p; bit rid; int cyc; bit ok; int n; int seen; logic [31:0] a, b;
    a = $urandom; b = $urandom;
    @(negedge clk);
    req0_a = a; req0_b = b; req0_signed = 1'b0; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (acc_start !== 1'b1 || mul_a_byte !== 8'(a & 32'hFF) || mul_b_byte !== 8'((b >> 16) & 32'hFF)) begin
      errors++; $display("FAIL step8_bytes got start=%b %h/%h want 1 %h/%h", acc_start, mul_a_byte, mul_b_byte,
                         8'(a & 32'hFF), 8'((b >> 16) & 32'hFF));
    end
    reset_n = 1'b0; #1;
    checks++;
    if ({busy, rsp_valid, acc_start} !== 3'b0 || {mul_a_byte, mul_b_byte} !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs got busy=%b valid=%b start=%b bytes=%h/%h want all 0", busy, rsp_valid, acc_start, mul_a_byte, mul_b_byte);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (rsp_valid || busy) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_rsp got %0d active cycles want 0", seen); end
    run_op(1'b0, 32'h10, 32'h10, 1'b0, p, rid, cyc, ok);
    checks++;
    if (!ok || p !== 64'h100 || cyc !== 19) begin
      errors++; $display("FAIL midrst_next got ok=%b product=%h latency=%0d want 1/%h/19", ok, p, cyc, 64'h100);
    end
    finish_rsp();
  endtask

  task automatic test_signed();
    logic [63:0] p, exp; bit rid; int cyc; bit ok;
    exp = SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1;
    run_op(1'b0, 32'hFFFF_FFFD, 32'h5, 1'b1, p, rid, cyc, ok);
    checks++;
    if (!ok || p !== exp) begin errors++; $display("FAIL signed_m3x5 got %h want %h", p, exp); end
    finish_rsp();
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, p, rid, cyc, ok);
    checks++;
    if (!ok || p !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL signed_min_sq got %h want %h", p, 64'h4000_0000_0000_0000);
    end
    finish_rsp();
    exp = SIGNED_EN ? 64'd63 : 64'hFFFF_FFF0_0000_003F;
    run_op(1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 1'b1, p, rid, cyc, ok);
    checks++;
    if (!ok || p !== exp) begin errors++; $display("FAIL signed_neg_neg got %h want %h", p, exp); end
    finish_rsp();
  endtask

  task automatic test_random();
    logic [63:0] p, exp; bit rid, id, s; int cyc; bit ok; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      id = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      if (i == 0) a = 32'h0;
      if (i == 1) b = 32'h8000_0000;
      if (i == 2) a = 32'h7FFF_FFFF;
      exp = ref_mul(a, b, s);
      run_op(id, a, b, s, p, rid, cyc, ok);
      checks++;
      if (!ok || p !== exp) begin
        errors++; $display("FAIL random_product %0d a=%h b=%h s=%b got %h want %h", i, a, b, s, p, exp);
      end
      checks++;
      if (rid !== id || cyc !== 19) begin
        errors++; $display("FAIL random_id_latency %0d got id=%b lat=%0d want %b/19", i, rid, cyc, id);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish_rsp();
    end
    checks++;
    if (ready_busy_seen != 0) begin
      errors++; $display("FAIL ready_while_busy got %0d cycles want 0", ready_busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_signed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter ARB_INIT, default 0, requester holding round-robin priority after reset.
REQ-002 SHALL have ports clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have reqN_valid  in  1 and reqN_ready  out  1 (N=0,1), requester handshake.
REQ-004 SHALL have reqN_a, reqN_b  in  32 each, operands, and reqN_signed  in  1, signed-operation flag.
REQ-005 SHALL have rsp_valid  out  1, rsp_ready  in  1, rsp_id  out  1 (served requester), rsp_product  out  64.
REQ-006 SHALL have mul_a_byte, mul_b_byte  out  8 each, operand bytes to the combinational 8x8 multiplier.
REQ-007 SHALL have acc_start  out  1 and acc_product  in  64, the start and result of the 16-step partial-product accumulator.
REQ-008 SHALL have busy  out  1, high in every state except IDLE.

Function
REQ-009 SHALL implement states IDLE, START, RUN, CAPTURE and RESP.
REQ-010 SHALL assert reqN_ready only in IDLE, for at most one requester per cycle, and only for the granted requester.
REQ-011 Grant SHALL go to the only valid requester, or, if both are valid, to the requester not served last.
REQ-012 On an accept (valid&&ready), the block SHALL latch the operands, sign flag and id, then go to START.
REQ-013 START SHALL last one cycle with acc_start=1 and bytes 0, then go to RUN.
REQ-014 RUN SHALL last 16 cycles with step k=0..15 and acc_start=1.
REQ-015 In RUN, mul_a_byte SHALL be A byte k[1:0] and mul_b_byte B byte k[3:2] (order A0B0,A1B0,A2B0,A3B0,A0B1..A3B3).
REQ-016 CAPTURE SHALL last one cycle: latch acc_product into rsp_product and drive acc_start=0 (accumulator returns to idle).
REQ-017 RESP SHALL hold rsp_valid=1 with rsp_product and rsp_id stable until rsp_ready, then go to IDLE.
REQ-018 The first rsp_valid SHALL occur in the 19th cycle after the accepting edge.
REQ-019 Outside RUN, bytes SHALL be 0; outside START/RUN, acc_start SHALL be 0.
REQ-020 New reqN_valid during busy SHALL be held off (ready=0) and never dropped or corrupted.
REQ-021 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-022 reset_n low SHALL immediately force IDLE; all outputs 0 except reqN_ready, which follows REQ-010 (IDLE, valid-gated); priority to ARB_INIT.
REQ-023 Reset mid-operation SHALL abandon the operation with no response; the first post-reset request SHALL complete correctly.

Configuration
REQ-024 With SIGNED_MUL_EN defined, at accept the block SHALL latch operand magnitudes when reqN_signed=1, and in CAPTURE negate (two's complement, 64 bit) if operand signs differ; |0x8000_0000| = 0x8000_0000 unsigned.
REQ-025 Without SIGNED_MUL_EN, reqN_signed SHALL be ignored and all operations unsigned; the ports SHALL remain present.

Structure
REQ-026 Package mul_seq_pkg SHALL hold the state enum, PP_STEPS=16, BYTE_W=8, and the requester id type.
REQ-027 The 2-input round-robin arbiter SHALL be a sub-module rr_arb2; the FSM, step counter and operand latches stay in mul_seq_ctrl.

Verification
REQ-028 SHALL cover: req0 0x3 x 0x5, accumulator model attached -> rsp_product 0xF, rsp_id 0, rsp_valid 19 cycles after accept.
REQ-029 SHALL cover: req1 unsigned 0xFFFFFFFF x 0xFFFFFFFF -> rsp_product 0xFFFFFFFE_00000001, byte pairs check (A0,B0),(A1,B0)..(A3,B3) order.
REQ-030 SHALL cover: both requesters valid continuously from reset, ARB_INIT=0 -> grants 0,1,0,1, ready never high for both.
REQ-031 SHALL cover: rsp_ready low 5 cycles in RESP -> rsp_product/rsp_id stable, no accept, busy=1 throughout.
REQ-032 SHALL cover: reset_n low at RUN step 8 -> outputs 0 immediately, no rsp; next request 0x10 x 0x10 -> 0x100.
REQ-033 SHALL cover, SIGNED_MUL_EN: -3 x 5 signed -> 0xFFFFFFFF_FFFFFFF1; 0x80000000 x 0x80000000 signed -> 0x40000000_00000000; without macro, -3 x 5 -> 0x00000004_FFFFFFF1.
